// File: rtl/equation_tx_pkg.sv
// equation_tx shared definitions: token kinds, ASCII codes, grammar states,
// token legality checks and token-to-ASCII conversion.
package equation_pkg;

   localparam logic [1:0] KIND_LETTER = 2'b00;
   localparam logic [1:0] KIND_DIGIT  = 2'b01;
   localparam logic [1:0] KIND_OP     = 2'b10;
   localparam logic [1:0] KIND_DELIM  = 2'b11;

   localparam logic [7:0] ASCII_NUL  = 8'h00;
   localparam logic [7:0] ASCII_A    = 8'h61;
   localparam logic [7:0] ASCII_0    = 8'h30;
   localparam logic [7:0] ASCII_PLUS = 8'h2B;
   localparam logic [7:0] ASCII_STAR = 8'h2A;
   localparam logic [7:0] ASCII_EQ   = 8'h3D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;

   typedef enum logic [1:0] {EXP_OPND, EXP_OP, EXP_OPND_R, EXP_OP_R} gram_state_t;

   // Value field within the range defined for its kind.
   function automatic logic tok_in_range(input logic [6:0] t);
      logic ok;
      case (t[6:5])
         KIND_LETTER: ok = (t[4:0] <= 5'd25);
         KIND_DIGIT:  ok = (t[4:0] <= 5'd9);
         default:     ok = (t[4:1] == 4'd0);
      endcase
      return ok;
   endfunction

   // Only called on in-range tokens.
   function automatic logic [7:0] tok_to_ascii(input logic [6:0] t);
      logic [7:0] c;
      case (t[6:5])
         KIND_LETTER: c = ASCII_A + {3'b000, t[4:0]};
         KIND_DIGIT:  c = ASCII_0 + {3'b000, t[4:0]};
         KIND_OP:     c = t[0] ? ASCII_STAR : ASCII_PLUS;
         default:     c = t[0] ? ASCII_LF : ASCII_EQ;
      endcase
      return c;
   endfunction

   function automatic logic gram_legal(input gram_state_t s, input logic [6:0] t);
      logic ok;
      case (t[6:5])
         KIND_LETTER, KIND_DIGIT: ok = (s == EXP_OPND) || (s == EXP_OPND_R);
         KIND_OP:                 ok = (s == EXP_OP) || (s == EXP_OP_R);
         default:                 ok = t[0] ? (s == EXP_OP_R) : (s == EXP_OP);
      endcase
      return ok;
   endfunction

   // Next state, meaningful only when gram_legal() holds for the same token.
   function automatic gram_state_t gram_next(input gram_state_t s, input logic [6:0] t);
      gram_state_t n;
      case (t[6:5])
         KIND_LETTER, KIND_DIGIT: n = (s == EXP_OPND_R) ? EXP_OP_R : EXP_OP;
         KIND_OP:                 n = (s == EXP_OP_R) ? EXP_OPND_R : EXP_OPND;
         default:                 n = t[0] ? EXP_OPND : EXP_OPND_R;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/equation_tx_if.sv
// Token producer / character consumer bundle for equation_tx.
interface equation_tx_if;
   logic       push;
   logic [6:0] tok;
   logic       en;
   logic       full;
   logic [7:0] out;
   logic       out_valid;
   logic       err;

   modport master (output push, tok, en, input full, out, out_valid, err);
   modport slave  (input push, tok, en, output full, out, out_valid, err);
endinterface

// File: rtl/equation_tx_fifo.sv
// Synchronous FIFO, power-of-two depth, registered full flag.
module equation_tx_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 7
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr, r_rptr;
   logic [AW:0]      r_count, w_count_d;
   logic             r_full;
   logic             w_do_push, w_do_pop;

   assign w_do_push = i_push && !r_full;
   assign w_do_pop  = i_pop && (r_count != '0);

   // Occupancy after this edge.
   always_comb begin
      w_count_d = r_count;
      if (w_do_push && !w_do_pop) begin
         w_count_d = r_count + 1'b1;
      end else if (!w_do_push && w_do_pop) begin
         w_count_d = r_count - 1'b1;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         r_count <= w_count_d;
         r_full  <= (w_count_d == (AW+1)'(DEPTH));
      end
   end

   // Storage needs no reset; the count qualifies every read.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_data;
   end

   assign o_data  = r_mem[r_rptr];
   assign o_full  = r_full;
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
endmodule

// File: rtl/equation_tx.sv
// Token-to-ASCII serializer feeding the equation recognizer.
// Optional grammar enforcement at push: define EQUATION_TX_GRAMMAR_EN.
module equation_tx
   import equation_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   equation_tx_if.slave  bus
);
   typedef enum logic [0:0] {StIdle, StEmit} emit_state_t;

   emit_state_t            r_state;
   logic [7:0]             r_out;
   logic                   r_err;
   logic                   w_in_range, w_gram_ok, w_accept, w_pop;
   logic                   w_full, w_empty;
   logic [6:0]             w_head;
   logic [$clog2(DEPTH):0] w_count;

   assign w_in_range = tok_in_range(bus.tok);

`ifdef EQUATION_TX_GRAMMAR_EN
   gram_state_t r_gram;

   assign w_gram_ok = gram_legal(r_gram, bus.tok);

   // Tracker advances on accepted tokens only, so queued tokens are always legal.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_gram <= EXP_OPND;
      end else if (w_accept) begin
         r_gram <= gram_next(r_gram, bus.tok);
      end
   end
`else
   assign w_gram_ok = 1'b1;
`endif

   // Full blocks the push even when a pop happens on the same edge.
   assign w_accept = bus.push && w_in_range && w_gram_ok && !w_full;
   assign w_pop    = bus.en && !w_empty;

   equation_tx_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (7)
   ) u_fifo (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_push  (w_accept),
      .i_data  (bus.tok),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Emitter: register the head's ASCII code on every pop, NUL otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= StIdle;
         r_out   <= ASCII_NUL;
      end else if (w_pop) begin
         r_state <= StEmit;
         r_out   <= tok_to_ascii(w_head);
      end else begin
         r_state <= StIdle;
         r_out   <= ASCII_NUL;
      end
   end

   // One-cycle drop indication for overflow, range or grammar rejects.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else begin
         r_err <= bus.push && !w_accept;
      end
   end

   // Popping is only ever attempted from a non-empty queue.
   assert property (@(posedge clk) disable iff (!reset) w_pop |-> (w_count != '0));

   assign bus.full      = w_full;
   assign bus.out       = r_out;
   assign bus.out_valid = (r_state == StEmit);
   assign bus.err       = r_err;
endmodule

// File: tb/tb_equation_tx.sv
// Directed bench for equation_tx: vector table plus multi-cycle sequences.
module tb_equation_tx;
   localparam int unsigned DEPTH = 8;
   localparam logic [1:0] KL = 2'b00, KD = 2'b01, KO = 2'b10, KM = 2'b11;

   logic clk = 1'b0;
   logic reset;
   equation_tx_if bus ();

   equation_tx #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       push;
      logic [6:0] tok;
      logic       en;
      logic [7:0] out;
      logic       vld;
      logic       err;
      logic       full;
   } vec_t;

   vec_t       tbl [18];
   logic [6:0] fill_tok [8];

   function automatic logic [6:0] tk(input logic [1:0] k, input int v);
      return {k, v[4:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic p, input logic [6:0] t, input logic e);
      bus.push = p;
      bus.tok  = t;
      bus.en   = e;
      @(posedge clk);
      #1;
      bus.push = 1'b0;
   endtask

   task automatic do_reset();
      bus.push = 1'b0;
      bus.en   = 1'b0;
      #2 reset = 1'b0;
      #3 reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Drain with en high for a bounded number of cycles and compare the characters.
   task automatic drain(input string exp, input int budget, input string name);
      int got = 0;
      for (int c = 0; c < budget; c++) begin
         cyc(1'b0, 7'd0, 1'b1);
         if (bus.out_valid === 1'b1) begin
            if (got < exp.len()) chk($sformatf("%s char%0d", name, got), bus.out, exp[got]);
            got++;
         end
      end
      chk({name, " count"}, got, exp.len());
   endtask

   task automatic fill8();
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, fill_tok[i], 1'b0);
         chk($sformatf("fill%0d full", i), bus.full, (i == 7));
         chk($sformatf("fill%0d err", i), bus.err, 1'b0);
      end
   endtask

   initial begin
      reset    = 1'b0;
      bus.push = 1'b0;
      bus.tok  = '0;
      bus.en   = 1'b0;
      #1;
      chk("reset out", bus.out, 8'h00);
      chk("reset valid", bus.out_valid, 1'b0);
      chk("reset err", bus.err, 1'b0);
      chk("reset full", bus.full, 1'b0);
      #7 reset = 1'b1;
      @(posedge clk);
      #1;

      // Stream "a+p*0=a*z\n9", then out-of-range drops.
      tbl[0]  = '{1'b1, tk(KL, 0),  1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, tk(KO, 0),  1'b1, 8'h61, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, tk(KL, 15), 1'b1, 8'h2B, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, tk(KO, 1),  1'b1, 8'h70, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, tk(KD, 0),  1'b1, 8'h2A, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, tk(KM, 0),  1'b1, 8'h30, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, tk(KL, 0),  1'b1, 8'h3D, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, tk(KO, 1),  1'b1, 8'h61, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, tk(KL, 25), 1'b1, 8'h2A, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, tk(KM, 1),  1'b1, 8'h7A, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{1'b1, tk(KD, 9),  1'b1, 8'h0A, 1'b1, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 7'd0,       1'b1, 8'h39, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 7'd0,       1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{1'b1, tk(KL, 26), 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[14] = '{1'b1, tk(KD, 12), 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[15] = '{1'b1, tk(KO, 2),  1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[16] = '{1'b1, tk(KM, 3),  1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[17] = '{1'b0, 7'd0,       1'b1, 8'h00, 1'b0, 1'b0, 1'b0};

      fill_tok[0] = tk(KL, 0); fill_tok[1] = tk(KO, 0);
      fill_tok[2] = tk(KL, 1); fill_tok[3] = tk(KO, 0);
      fill_tok[4] = tk(KL, 2); fill_tok[5] = tk(KO, 0);
      fill_tok[6] = tk(KL, 3); fill_tok[7] = tk(KO, 0);

      for (int i = 0; i < 18; i++) begin
         cyc(tbl[i].push, tbl[i].tok, tbl[i].en);
         chk($sformatf("vec%0d out", i), bus.out, tbl[i].out);
         chk($sformatf("vec%0d valid", i), bus.out_valid, tbl[i].vld);
         chk($sformatf("vec%0d err", i), bus.err, tbl[i].err);
         chk($sformatf("vec%0d full", i), bus.full, tbl[i].full);
      end

      // Overflow: fill, push while full, push again on the first popping edge.
      do_reset();
      fill8();
      cyc(1'b1, tk(KL, 4), 1'b0);
      chk("ovf err", bus.err, 1'b1);
      chk("ovf full", bus.full, 1'b1);
      chk("ovf valid", bus.out_valid, 1'b0);
      cyc(1'b1, tk(KL, 4), 1'b1);
      chk("ovf pop err", bus.err, 1'b1);
      chk("ovf pop out", bus.out, 8'h61);
      chk("ovf pop full", bus.full, 1'b0);
      drain("+b+c+d+", 12, "ovf drain");

      // Leading operator.
      do_reset();
      cyc(1'b1, tk(KO, 0), 1'b1);
`ifdef EQUATION_TX_GRAMMAR_EN
      chk("lead op err", bus.err, 1'b1);
      drain("", 3, "lead op");
`else
      chk("lead op err", bus.err, 1'b0);
      drain("+", 3, "lead op");
`endif

      // Double '=' after an operand.
      do_reset();
      cyc(1'b1, tk(KL, 0), 1'b0);
      cyc(1'b1, tk(KM, 0), 1'b0);
      chk("eq1 err", bus.err, 1'b0);
      cyc(1'b1, tk(KM, 0), 1'b0);
`ifdef EQUATION_TX_GRAMMAR_EN
      chk("eq2 err", bus.err, 1'b1);
      drain("a=", 5, "double eq");
`else
      chk("eq2 err", bus.err, 1'b0);
      drain("a==", 5, "double eq");
`endif

      // Asynchronous reset clears full without a clock edge.
      do_reset();
      fill8();
      #3 reset = 1'b0;
      #1;
      chk("async full", bus.full, 1'b0);
      #1 reset = 1'b1;
      drain("", 3, "after async full");

      // Asynchronous reset mid-stream with tokens queued and a character on out.
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1'b1, fill_tok[i], 1'b0);
      cyc(1'b0, 7'd0, 1'b1);
      chk("mid out", bus.out, 8'h61);
      chk("mid valid", bus.out_valid, 1'b1);
      #3 reset = 1'b0;
      #1;
      chk("async out", bus.out, 8'h00);
      chk("async valid", bus.out_valid, 1'b0);
      chk("async full2", bus.full, 1'b0);
      #1 reset = 1'b1;
      cyc(1'b1, tk(KL, 1), 1'b1);
      chk("post rst err", bus.err, 1'b0);
      chk("post rst valid", bus.out_valid, 1'b0);
      drain("b", 4, "post rst");

      // en toggled 1,0,1 across a 4-token stream.
      do_reset();
      cyc(1'b1, tk(KL, 0), 1'b0);
      cyc(1'b1, tk(KO, 0), 1'b0);
      cyc(1'b1, tk(KL, 1), 1'b0);
      cyc(1'b1, tk(KO, 1), 1'b0);
      cyc(1'b0, 7'd0, 1'b1);
      chk("tog0 out", bus.out, 8'h61);
      chk("tog0 valid", bus.out_valid, 1'b1);
      cyc(1'b0, 7'd0, 1'b0);
      chk("gap out", bus.out, 8'h00);
      chk("gap valid", bus.out_valid, 1'b0);
      drain("+b*", 5, "toggle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/equation_tx.md
# equation_tx

Token-to-ASCII serializer that produces the character stream consumed by the `equation` recognizer: one 8-bit ASCII character per clock on `out`. A producer pushes compact tokens (operand, operator, `=`, end-of-line) into an internal FIFO. The block drains the FIFO at one character per enabled cycle, optionally enforcing equation grammar before emission. It sits directly upstream of `equation` and doubles as its stimulus source in system benches.

## Interface
- `DEPTH`, default 8: FIFO entries; power of two, 2..64.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; asserted when 0.
- `push`  in  1  token write strobe.
- `tok`  in  7  token; [6:5] kind (00 letter, 01 digit, 10 operator, 11 delimiter), [4:0] value.
- `en`  in  1  drain enable; when low, the FIFO head is held.
- `full`  out  1  FIFO holds DEPTH tokens.
- `out`  out  8  ASCII character to the recognizer.
- `out_valid`  out  1  `out` carries a character this cycle.
- `err`  out  1  one-cycle pulse: token dropped (overflow or grammar).

## Operation
- Encoding:
  - letter v (0..25) -> 8'h61+v.
  - digit v (0..9) -> 8'h30+v.
  - operator 0 -> `+` (8'h2B), operator 1 -> `*` (8'h2A).
  - delimiter 0 -> `=` (8'h3D), delimiter 1 -> LF (8'h0A).
- Out-of-range values (letter >25, digit >9, operator >1, delimiter >1) are illegal in every build; they are dropped at push and `err` pulses.
- FIFO:
  - Push while `full` is dropped with `err` pulsed, even if a pop occurs in the same cycle.
  - Push into an empty FIFO while `en` is high is legal; the token enters the FIFO and does not bypass it.
- Emitter FSM:
  - IDLE: FIFO empty or `en` low; `out`=8'h00, `out_valid`=0.
  - EMIT: FIFO non-empty and `en` high; pop the head and register its ASCII code.
  - IDLE->EMIT and EMIT->IDLE are evaluated every cycle from the FIFO count and `en`.
- Grammar tracker (build-dependent, see Configuration): state {EXP_OPND, EXP_OP, EXP_OPND_R, EXP_OP_R}.
  - Start in EXP_OPND.
  - Operand: EXP_OPND -> EXP_OP; EXP_OPND_R -> EXP_OP_R.
  - Operator: EXP_OP -> EXP_OPND; EXP_OP_R -> EXP_OPND_R.
  - `=` is legal only in EXP_OP -> EXP_OPND_R.
  - LF is legal only in EXP_OP_R -> EXP_OPND.
  - Any other token is illegal.
  - The tracker is evaluated at push time on accepted tokens only, so the FIFO contents are always legal.

## Timing
- Reset values: `out`=8'h00, `out_valid`=0, `err`=0, `full`=0, FIFO empty, grammar state EXP_OPND.
- Reset mid-stream discards all queued tokens immediately, without waiting for a clock edge.
- Latency: token pushed at edge N into an empty FIFO with `en` high -> `out`/`out_valid` valid after edge N+1.
- Throughput: one character per cycle while `en` is high and the FIFO is non-empty.
- `en` deasserted at edge N: no pop at N; `out_valid`=0 after N, and `out` returns to 8'h00.
- `err` is registered: asserted during the cycle after the offending push edge.
- `full` is registered and reflects the count after each edge. Simultaneous push and pop at count DEPTH-1 leaves the count unchanged.
- Pointers wrap modulo DEPTH; the count is log2(DEPTH)+1 bits.

## Configuration
- `EQUATION_TX_GRAMMAR_EN` defined:
  - The grammar tracker is compiled in.
  - Grammar-illegal tokens are dropped at push with `err` pulsed; they do not consume FIFO space.
- Not defined:
  - The tracker is absent.
  - Any in-range token is accepted and emitted verbatim.
  - `err` flags only overflow and out-of-range values.

## Structure
- Package `equation_pkg`:
  - kind constants KIND_LETTER, KIND_DIGIT, KIND_OP, KIND_DELIM.
  - ASCII constants.
  - grammar state enum.
  - token-to-ASCII function.
- Sub-module `equation_tx_fifo`: parameterized synchronous FIFO with push/pop/full/empty/count. The top holds the emitter FSM and the grammar tracker.

## Test plan
- Push letter 0, op 0, letter 15, op 1, digit 0, delim 0, letter 0, op 1, `en`=1 -> `out` sequence `a+p*0=a*` on consecutive cycles, first character one cycle after the first push.
- Fill to DEPTH with `en`=0, then push once more -> `full`=1, `err` pulses, FIFO count unchanged. Raise `en` -> exactly DEPTH characters emitted.
- With `EQUATION_TX_GRAMMAR_EN`, push op 0 first -> `err` pulses, nothing emitted. Push `=` twice after an operand -> the second `=` is dropped. Without the macro, the same stimulus emits `+` and `==`.
- Push letter 26 and digit 12 -> both dropped, `err` pulses twice, `out_valid` stays 0.
- Drop `reset` to 0 mid-stream with 5 tokens queued -> `out`=8'h00, `out_valid`=0 and `full`=0 immediately. After release, the next token `b` is emitted alone.
- Toggle `en` 1,0,1 during a 4-token stream -> no character duplicated or lost, and `out`=8'h00 in the gap cycle.
